// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   owner_t            - arbitration owner state (IDLE, OWN0, OWN1)
//   PORT0 / PORT1      - requester port indices, also the last_winner encoding
//   DEFAULT_DEPTH      - default number of memory words
//   DEFAULT_BURST_MAX  - default bound on consecutive grants while the other port waits
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEFAULT_DEPTH     = 256;
    localparam int DEFAULT_BURST_MAX = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for a shared single-port data memory
// (combinational read, synchronous write). Port 0 is the MEM pipeline stage,
// port 1 the loader/debug path. One access is granted per cycle, round-robin
// with a bounded ownership burst; the response comes back one cycle later.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   pX_req/we/addr/wdata (X=0,1)     requester access; held stable until pX_gnt
//   pX_gnt                           access performed this cycle (combinational)
//   pX_rvalid/rdata/err              one-cycle-later response for each grant
//   mem_we/re/addr/wdata             memory drive for the granted access
//   mem_rdata                        memory combinational read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int BURST_MAX  = DEFAULT_BURST_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_err,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,

    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Widened by one bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          BURST_LIM = 4'(BURST_MAX);

    // Ports gathered into indexable form so per-port logic can be generated.
    logic [1:0]            req;
    logic [1:0]            we;
    logic [1:0]            gnt;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [DATA_WIDTH-1:0] wdata [2];

    assign req      = {p1_req, p0_req};
    assign we       = {p1_we, p0_we};
    assign addr[0]  = p0_addr;
    assign addr[1]  = p1_addr;
    assign wdata[0] = p0_wdata;
    assign wdata[1] = p1_wdata;

    owner_t     owner_reg, owner_next;
    logic       last_winner_reg, last_winner_next;
    logic [3:0] burst_cnt_reg, burst_cnt_next;

    logic                  any_gnt;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  in_range;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg       <= IDLE;
            last_winner_reg <= PORT1;   // makes port 0 win the first tie
            burst_cnt_reg   <= '0;
        end else begin
            owner_reg       <= owner_next;
            last_winner_reg <= last_winner_next;
            burst_cnt_reg   <= burst_cnt_next;
        end
    end

    // Next-owner selection, grants, burst accounting and memory drive.
    always_comb begin
        owner_next       = IDLE;
        gnt              = 2'b00;
        last_winner_next = last_winner_reg;
        burst_cnt_next   = '0;
        sel_we           = 1'b0;
        sel_addr         = '0;
        sel_wdata        = '0;

        case (owner_reg)
            IDLE: begin
                if (req[0] && req[1]) begin
                    owner_next = (last_winner_reg == PORT1) ? OWN0 : OWN1;
                end else if (req[0]) begin
                    owner_next = OWN0;
                end else if (req[1]) begin
                    owner_next = OWN1;
                end
            end
            OWN0: begin
                if (req[0]) begin
                    // The waiting port takes over once the burst bound is reached.
                    owner_next = (burst_cnt_reg == BURST_LIM && req[1]) ? OWN1 : OWN0;
                end else if (req[1]) begin
                    owner_next = OWN1;
                end
            end
            OWN1: begin
                if (req[1]) begin
                    owner_next = (burst_cnt_reg == BURST_LIM && req[0]) ? OWN0 : OWN1;
                end else if (req[0]) begin
                    owner_next = OWN0;
                end
            end
            default: owner_next = IDLE;
        endcase

        // Grants are suppressed while reset is asserted so no access leaks out.
        gnt[0] = rst_n & req[0] & (owner_next == OWN0);
        gnt[1] = rst_n & req[1] & (owner_next == OWN1);

        if (gnt[0]) begin
            last_winner_next = PORT0;
            sel_we           = we[0];
            sel_addr         = addr[0];
            sel_wdata        = wdata[0];
        end else if (gnt[1]) begin
            last_winner_next = PORT1;
            sel_we           = we[1];
            sel_addr         = addr[1];
            sel_wdata        = wdata[1];
        end

        if (owner_next == IDLE) begin
            burst_cnt_next = '0;
        end else if (owner_next != owner_reg) begin
            burst_cnt_next = 4'd1;
        end else if (burst_cnt_reg == BURST_LIM) begin
            burst_cnt_next = burst_cnt_reg;
        end else begin
            burst_cnt_next = burst_cnt_reg + 4'd1;
        end
    end

    assign any_gnt   = |gnt;
    assign in_range  = ({1'b0, sel_addr} < DEPTH_LIM);
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;
    assign mem_we    = any_gnt & sel_we & in_range;
    assign mem_re    = any_gnt & ~sel_we & in_range;

    // Per-port response pipeline. Only the granted port captures anything;
    // writes and out-of-range accesses return zero data.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            logic                  rvalid_reg;
            logic                  err_reg;
            logic [DATA_WIDTH-1:0] rdata_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rvalid_reg <= 1'b0;
                    err_reg    <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= gnt[gi];
                    err_reg    <= gnt[gi] & ~in_range;
                    rdata_reg  <= (gnt[gi] && !we[gi] && in_range) ? mem_rdata : '0;
                end
            end
        end
    endgenerate

    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign p0_rvalid = g_resp[0].rvalid_reg;
    assign p0_err    = g_resp[0].err_reg;
    assign p0_rdata  = g_resp[0].rdata_reg;
    assign p1_rvalid = g_resp[1].rvalid_reg;
    assign p1_err    = g_resp[1].err_reg;
    assign p1_rdata  = g_resp[1].rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 256-word memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory model: combinational read on the low address bits, synchronous
    // write. Address 256 aliases word 0, so an ungated out-of-range write shows.
    logic [31:0] mem [0:255];
    bit          preloaded = 1'b0;

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (!preloaded) begin
            mem[0]    <= 32'd8;
            mem[4]    <= 32'd1;
            mem[10]   <= 32'd0;
            mem[255]  <= 32'hA5A5_0255;
            preloaded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic w, input logic [31:0] a, input logic [31:0] d);
        p0_req = req; p0_we = w; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set_p1(input logic req, input logic w, input logic [31:0] a, input logic [31:0] d);
        p1_req = req; p1_we = w; p1_addr = a; p1_wdata = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_p0(1'b1, 1'b1, 32'd4, 32'h1111_1111);
        set_p1(1'b1, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: gnt=%b%b required 00", p1_gnt, p0_gnt); end
        n_checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: we=%b re=%b required 0 0", mem_we, mem_re); end
        n_checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || p0_err !== 1'b0 || p1_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp: rvalid=%b%b err=%b%b required 0", p1_rvalid, p0_rvalid, p1_err, p0_err); end
        n_checks++; if (p0_rdata !== 32'd0 || p1_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: %h %h required 0", p0_rdata, p1_rdata); end
        $display("txn reset held with both ports requesting");
        do_reset();
    endtask

    task automatic test_single_read();
        set_p0(1'b1, 1'b0, 32'd4, 32'd0);
        #1;
        $display("txn p0 read addr=4 gnt=%b", p0_gnt);
        n_checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin n_fail++; $display("FAIL rd_gnt: gnt=%b%b required 01", p1_gnt, p0_gnt); end
        n_checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd4) begin n_fail++; $display("FAIL rd_mem: re=%b we=%b addr=%h required 1 0 4", mem_re, mem_we, mem_addr); end
        tick();
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        n_checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'd1 || p0_err !== 1'b0) begin n_fail++; $display("FAIL rd_resp: rvalid=%b rdata=%h err=%b required 1 1 0", p0_rvalid, p0_rdata, p0_err); end
        n_checks++; if (p1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_other_port: p1_rvalid=%b required 0", p1_rvalid); end
        #1;
        n_checks++; if (mem_addr !== 32'd0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL idle_mem: addr=%h re=%b required 0 0", mem_addr, mem_re); end
        tick();
        n_checks++; if (p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_single_pulse: p0_rvalid=%b required 0", p0_rvalid); end
    endtask

    task automatic test_tie();
        // Per cycle: requests (p1,p0) and the expected grants (p1,p0).
        logic [1:0] reqs [6] = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b00, 2'b11};
        logic [1:0] gnts [6] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_p0(reqs[i][0], 1'b0, 32'd4, 32'd0);
            set_p1(reqs[i][1], 1'b0, 32'd0, 32'd0);
            #1;
            $display("txn tie cycle %0d req=%b gnt=%b%b", i, reqs[i], p1_gnt, p0_gnt);
            n_checks++; if ({p1_gnt, p0_gnt} !== gnts[i]) begin n_fail++; $display("FAIL tie_gnt[%0d]: gnt=%b%b required %b", i, p1_gnt, p0_gnt, gnts[i]); end
            tick();
            n_checks++; if ({p1_rvalid, p0_rvalid} !== gnts[i]) begin n_fail++; $display("FAIL tie_rvalid[%0d]: rvalid=%b%b required %b", i, p1_rvalid, p0_rvalid, gnts[i]); end
        end
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_burst();
        // Bit i set means port 0 is expected to hold the grant in cycle i.
        logic [9:0] pat = 10'b11_0000_1111;
        do_reset();
        set_p0(1'b1, 1'b0, 32'd4, 32'd0);
        set_p1(1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            #1;
            $display("txn burst cycle %0d gnt=%b%b", i, p1_gnt, p0_gnt);
            n_checks++; if (p0_gnt !== pat[i] || p1_gnt !== !pat[i]) begin n_fail++; $display("FAIL burst_gnt[%0d]: gnt=%b%b required p0=%b", i, p1_gnt, p0_gnt, pat[i]); end
            tick();
            if (pat[i]) begin
                n_checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'd1) begin n_fail++; $display("FAIL burst_p0_resp[%0d]: rvalid=%b rdata=%h required 1 1", i, p0_rvalid, p0_rdata); end
            end else begin
                n_checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'd8) begin n_fail++; $display("FAIL burst_p1_resp[%0d]: rvalid=%b rdata=%h required 1 8", i, p1_rvalid, p1_rdata); end
            end
        end
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_out_of_range();
        set_p1(1'b1, 1'b1, 32'd256, 32'hDEAD_BEEF);
        #1;
        $display("txn p1 write addr=256 data=deadbeef gnt=%b", p1_gnt);
        n_checks++; if (p1_gnt !== 1'b1 || mem_we !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL oor_wr_gnt: gnt=%b mem_we=%b mem_re=%b required 1 0 0", p1_gnt, mem_we, mem_re); end
        tick();
        n_checks++; if (p1_rvalid !== 1'b1 || p1_err !== 1'b1 || p1_rdata !== 32'd0) begin n_fail++; $display("FAIL oor_wr_resp: rvalid=%b err=%b rdata=%h required 1 1 0", p1_rvalid, p1_err, p1_rdata); end
        set_p1(1'b1, 1'b0, 32'd0, 32'd0);
        #1;
        $display("txn p1 read addr=0 gnt=%b", p1_gnt);
        tick();
        n_checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'd8 || p1_err !== 1'b0) begin n_fail++; $display("FAIL oor_addr0_kept: rvalid=%b rdata=%h err=%b required 1 8 0", p1_rvalid, p1_rdata, p1_err); end
        set_p1(1'b1, 1'b0, 32'd255, 32'd0);
        #1;
        $display("txn p1 read addr=255 gnt=%b", p1_gnt);
        n_checks++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL last_word_re: mem_re=%b required 1", mem_re); end
        tick();
        n_checks++; if (p1_rdata !== 32'hA5A5_0255 || p1_err !== 1'b0) begin n_fail++; $display("FAIL last_word_resp: rdata=%h err=%b required a5a50255 0", p1_rdata, p1_err); end
        set_p1(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0);
        #1;
        $display("txn p1 read addr=ffffffff gnt=%b", p1_gnt);
        n_checks++; if (p1_gnt !== 1'b1 || mem_re !== 1'b0) begin n_fail++; $display("FAIL oor_rd_re: gnt=%b mem_re=%b required 1 0", p1_gnt, mem_re); end
        tick();
        n_checks++; if (p1_err !== 1'b1 || p1_rdata !== 32'd0) begin n_fail++; $display("FAIL oor_rd_resp: err=%b rdata=%h required 1 0", p1_err, p1_rdata); end
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_back_to_back_raw();
        set_p0(1'b1, 1'b1, 32'd10, 32'h1234_5678);
        #1;
        $display("txn p0 write addr=10 data=12345678 gnt=%b", p0_gnt);
        n_checks++; if (p0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd10 || mem_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL raw_wr_mem: gnt=%b we=%b addr=%h wdata=%h required 1 1 a 12345678", p0_gnt, mem_we, mem_addr, mem_wdata); end
        tick();
        n_checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'd0 || p0_err !== 1'b0) begin n_fail++; $display("FAIL raw_wr_resp: rvalid=%b rdata=%h err=%b required 1 0 0", p0_rvalid, p0_rdata, p0_err); end
        set_p0(1'b1, 1'b0, 32'd10, 32'd0);
        #1;
        $display("txn p0 read addr=10 gnt=%b", p0_gnt);
        tick();
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        n_checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL raw_rd_resp: rvalid=%b rdata=%h required 1 12345678", p0_rvalid, p0_rdata); end
        set_p1(1'b1, 1'b0, 32'd10, 32'd0);
        #1;
        $display("txn p1 read addr=10 gnt=%b", p1_gnt);
        tick();
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        n_checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h1234_5678 || p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL raw_p1_resp: rvalid=%b rdata=%h p0_rvalid=%b required 1 12345678 0", p1_rvalid, p1_rdata, p0_rvalid); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        set_p1(1'b1, 1'b0, 32'd4, 32'd0);
        #1;
        $display("txn p1 read addr=4 gnt=%b", p1_gnt);
        tick();
        // p1 owns with a response pending; its next access is a write that must not land.
        set_p1(1'b1, 1'b1, 32'd10, 32'h0000_0BAD);
        #1;
        n_checks++; if (p1_rvalid !== 1'b1 || p1_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_pre: rvalid=%b gnt=%b required 1 1", p1_rvalid, p1_gnt); end
        rst_n = 1'b0;
        #1;
        $display("txn reset asserted while p1 owns");
        n_checks++; if (p1_gnt !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL mid_gnt: gnt=%b we=%b re=%b required 0 0 0", p1_gnt, mem_we, mem_re); end
        n_checks++; if (p1_rvalid !== 1'b0 || p1_err !== 1'b0 || p1_rdata !== 32'd0) begin n_fail++; $display("FAIL mid_resp: rvalid=%b err=%b rdata=%h required 0 0 0", p1_rvalid, p1_err, p1_rdata); end
        set_p0(1'b1, 1'b0, 32'd4, 32'd0);
        set_p1(1'b1, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (mem[10] !== 32'h1234_5678) begin n_fail++; $display("FAIL mid_no_write: mem[10]=%h required 12345678", mem[10]); end
        rst_n = 1'b1;
        #1;
        $display("txn reset released, both requesting gnt=%b%b", p1_gnt, p0_gnt);
        n_checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_restart: gnt=%b%b required 01", p1_gnt, p0_gnt); end
        tick();
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        n_checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'd1) begin n_fail++; $display("FAIL mid_restart_resp: rvalid=%b rdata=%h required 1 1", p0_rvalid, p0_rdata); end
        #1;
        n_checks++; if (p1_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_p1_next: p1_gnt=%b required 1", p1_gnt); end
        tick();
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_burst();
        test_out_of_range();
        test_back_to_back_raw();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer for the shared single-port data memory (256 x 32-bit words, combinational read, synchronous write).
- Port 0 serves the MEM pipeline stage; port 1 serves the program/data loader and debug path.
- Grants one access per cycle using round-robin with a bounded ownership burst.
- Gates out-of-range accesses, registers read data, and returns a one-cycle-later response per access.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 32, address width on requester and memory ports.
- DEPTH, 256, number of memory words; valid addresses are 0..DEPTH-1.
- BURST_MAX, 4, maximum consecutive grants to one owner while the other port waits; range 1..15.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 access request.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_WIDTH  port 0 word address.
- p0_wdata  in  DATA_WIDTH  port 0 write data.
- p0_gnt  out  1  port 0 access performed this cycle.
- p0_rvalid  out  1  port 0 response valid, one cycle after p0_gnt.
- p0_rdata  out  DATA_WIDTH  port 0 read data, valid with p0_rvalid.
- p0_err  out  1  port 0 out-of-range flag, valid with p0_rvalid.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err  same as port 0, for port 1.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory combinational read data.

Behaviour:
- State register owner is one of IDLE, OWN0, OWN1. Also kept: last_winner (1 bit), burst_cnt (4 bits).
- Reset values: owner=IDLE, last_winner=1 (port 0 wins the first tie), burst_cnt=0; all rvalid/err/rdata = 0.
- While rst_n is low, gnt, mem_we and mem_re are forced to 0 combinationally.
- next_owner is computed combinationally each cycle:
  - IDLE: a single requester wins. If both request, the port that is not last_winner wins. No requests gives IDLE.
  - OWNx with reqx=1: stays OWNx, unless burst_cnt==BURST_MAX and the other port requests, in which case it switches to the other port.
  - OWNx with reqx=0: switches to the other port if it requests, else goes to IDLE.
- gntX = (next_owner==OWNX) & reqX, combinational in the same cycle as the request. The access completes in that cycle.
- Registered on the edge: owner<=next_owner; last_winner<=granted port.
- burst_cnt becomes 1 on an ownership change and increments on a continued grant, saturating at BURST_MAX. It clears in IDLE.
- Memory drive for the granted port:
  - mem_addr=addr and mem_wdata=wdata.
  - Range check: in_range = addr < DEPTH, computed on the full ADDR_WIDTH.
  - mem_we = gnt & we & in_range.
  - mem_re = gnt & ~we & in_range.
  - With no grant: mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0.
- Response, one cycle after the grant:
  - pX_rvalid=1 for exactly one cycle per grant, for reads and writes alike.
  - pX_rdata = mem_rdata captured at the grant edge for an in-range read; 0 for writes and out-of-range accesses.
  - pX_err=1 if and only if the access was out of range. An out-of-range write modifies no memory.
  - The non-granted port's rvalid, err and rdata are 0.
- Back-to-back grants to one port give back-to-back rvalid pulses (throughput 1 access/cycle).
- Requester contract: hold req, we, addr and wdata stable until gnt. Fields may change in the cycle after gnt.
- Read-after-write to the same address on consecutive grants returns the new data, because the write lands at the grant edge.
- Reset mid-operation: a pending response is dropped (rvalid=0), no partial write is issued, and arbitration restarts with port 0 priority.

Decomposition:
- Package dmem_arb_pkg holds:
  - the owner state enum (IDLE, OWN0, OWN1);
  - port index constants (PORT0=0, PORT1=1);
  - default DEPTH and BURST_MAX.
- Single module. The round-robin next_owner logic is small enough to stay inline; no sub-module.

Test Plan:
- Single read: memory word 4 = 1; p0 reads addr 4 -> p0_gnt same cycle, mem_re=1, next cycle p0_rvalid=1 and p0_rdata=1, p0_err=0.
- Tie after reset: p0 and p1 request in the same cycle -> p0 granted first, then p1 next cycle. Two further ties alternate starting with p0.
- Burst bound: p0 holds req for 10 accesses while p1 requests continuously, BURST_MAX=4 -> grant pattern p0 x4, p1 x4, p0 x2. The waiting port never waits more than 4 cycles.
- Out-of-range: p1 writes 0xDEADBEEF to addr 256 -> p1_gnt=1, mem_we=0, next cycle p1_rvalid=1 and p1_err=1. A subsequent read of addr 0 returns its prior value 8.
- Read-after-write: p0 writes 0x12345678 to addr 10, then reads addr 10 on the next cycle -> second response p0_rdata=0x12345678. A read by p1 of addr 10 afterwards also returns it.
- Reset mid-burst: assert rst_n=0 while p1 owns with a read pending -> gnt, mem_we, rvalid and err go 0 immediately. After release with both requesting, p0 is granted first.
